// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared types and control encodings for the pipeline hazard/sequencing controller.
// Control vectors list the five register enables followed by the four flushes.
package riscv_pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_fl;
        logic id_ex_fl;
        logic ex_mem_fl;
        logic mem_wb_fl;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN          = 9'b11111_0000;
    localparam ctrl_t CTRL_BRANCH_FLUSH = 9'b11111_1100;
    localparam ctrl_t CTRL_LOAD_STALL   = 9'b00111_0100;
    // MEM/WB gets a bubble so the waiting access does not retire twice
    localparam ctrl_t CTRL_FREEZE       = 9'b00000_0001;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination
// of a load currently in EX.
module hazard_detect
    import riscv_pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_uses_rs1_i,
    input  logic                      id_uses_rs2_i,
    input  logic                      ex_mem_read_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    output logic                      hazard_o
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    assign rd_nonzero = |ex_rd_i;
    assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign hazard_o   = ex_mem_read_i && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller: load-use stalls, branch squashes,
// memory-wait freeze and saturating debug event counters.
module pipeline_controller
    import riscv_pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEM_LATENCY    = 2,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_branch_taken,
    input  logic                      mem_access,
    output logic                      pc_enable,
    output logic                      if_id_enable,
    output logic                      id_ex_enable,
    output logic                      ex_mem_enable,
    output logic                      mem_wb_enable,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      ex_mem_flush,
    output logic                      mem_wb_flush,
    output logic                      frozen,
    output logic [CNT_WIDTH-1:0]      stall_count,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    localparam int unsigned TW_RAW = $clog2(MEM_LATENCY);
    localparam int unsigned TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam bit          FRZ_EN = (MEM_LATENCY > 1);
    localparam int unsigned T_INIT = FRZ_EN ? MEM_LATENCY - 2 : 0;

    localparam logic [TW-1:0] TIMER_INIT = TW'(T_INIT);

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] flush_q, flush_d;

    ctrl_t ctrl;
    logic  frz;
    logic  advance;
    logic  load_use;
    logic  stall_ev;
    logic  flush_ev;

    hazard_detect #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .hazard_o      (load_use)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        frz     = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_access && FRZ_EN) begin
                    frz     = 1'b1;
                    state_d = MEM_WAIT;
                    timer_d = TIMER_INIT;
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (timer_q != '0) begin
                    frz     = 1'b1;
                    timer_d = timer_q - TW'(1);
                end else begin
                    advance = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                timer_d = '0;
            end
        endcase
    end

    // Freeze masks hazards; held ID/EX contents re-raise them on release
    always_comb begin
        ctrl     = CTRL_RUN;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        if (frz) begin
            ctrl     = CTRL_FREEZE;
            stall_ev = 1'b1;
        end else if (advance && ex_branch_taken) begin
            ctrl     = CTRL_BRANCH_FLUSH;
            flush_ev = 1'b1;
        end else if (advance && load_use) begin
            ctrl     = CTRL_LOAD_STALL;
            stall_ev = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_ev && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
        if (flush_ev && (flush_q != '1)) begin
            flush_d = flush_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            timer_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign pc_enable     = ctrl.pc_en;
    assign if_id_enable  = ctrl.if_id_en;
    assign id_ex_enable  = ctrl.id_ex_en;
    assign ex_mem_enable = ctrl.ex_mem_en;
    assign mem_wb_enable = ctrl.mem_wb_en;
    assign if_id_flush   = ctrl.if_id_fl;
    assign id_ex_flush   = ctrl.id_ex_fl;
    assign ex_mem_flush  = ctrl.ex_mem_fl;
    assign mem_wb_flush  = ctrl.mem_wb_fl;
    assign frozen        = frz;
    assign stall_count   = stall_q;
    assign flush_count   = flush_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench: vector table with scoreboarded expectations plus
// hand sequences for memory wait, combined events, reset and saturation.
module tb_pipeline_controller;

    localparam logic [8:0] E_RUN = 9'b11111_0000;
    localparam logic [8:0] E_BR  = 9'b11111_1100;
    localparam logic [8:0] E_LD  = 9'b00111_0100;
    localparam logic [8:0] E_FRZ = 9'b00000_0001;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_mem_read, ex_branch_taken, mem_access;
    logic       pc_enable, if_id_enable, id_ex_enable;
    logic       ex_mem_enable, mem_wb_enable;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       frozen;
    logic [3:0] stall_count, flush_count;

    pipeline_controller #(
        .REG_ADDR_WIDTH(5),
        .MEM_LATENCY   (3),
        .CNT_WIDTH     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_access     (mem_access),
        .pc_enable      (pc_enable),
        .if_id_enable   (if_id_enable),
        .id_ex_enable   (id_ex_enable),
        .ex_mem_enable  (ex_mem_enable),
        .mem_wb_enable  (mem_wb_enable),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .mem_wb_flush   (mem_wb_flush),
        .frozen         (frozen),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exr;
        logic [4:0] rd;
        logic       br;
        logic       mem;
        logic [8:0] ctrl;
        logic       frz;
    } vec_t;

    typedef struct {
        logic [8:0] ctrl;
        logic       frz;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_sc = 4'd0;
    logic [3:0] m_fc = 4'd0;

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic exr,
        input logic [4:0] rd, input logic br, input logic mem,
        input logic [8:0] ctrl, input logic frz);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exr = exr; v.rd = rd; v.br = br; v.mem = mem;
        v.ctrl = ctrl; v.frz = frz;
        return v;
    endfunction

    function automatic logic [3:0] sat_inc(
        input logic [3:0] c, input logic ev);
        if (ev && c != 4'hF) return c + 4'd1;
        return c;
    endfunction

    function automatic logic [8:0] act_ctrl();
        return {pc_enable, if_id_enable, id_ex_enable,
                ex_mem_enable, mem_wb_enable, if_id_flush,
                id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        ex_branch_taken = 1'b0; mem_access = 1'b0;
    endtask

    // Called at posedge+1; returns at the following posedge+1
    task automatic drive(input vec_t v, input string name);
        exp_t e;
        id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_mem_read = v.exr; ex_rd = v.rd;
        ex_branch_taken = v.br; mem_access = v.mem;
        m_sc = sat_inc(m_sc, v.frz || !v.ctrl[8]);
        m_fc = sat_inc(m_fc, v.ctrl[3]);
        e.ctrl = v.ctrl; e.frz = v.frz;
        e.sc = m_sc; e.fc = m_fc;
        sb.push_back(e);
        @(negedge clk);
        e = sb[0];
        check({name, "_ctrl"}, 32'(act_ctrl()), 32'(e.ctrl));
        check({name, "_frozen"}, 32'(frozen), 32'(e.frz));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({name, "_stall"}, 32'(stall_count), 32'(e.sc));
        check({name, "_flush"}, 32'(flush_count), 32'(e.fc));
    endtask

    initial begin
        vec_t idle_v;
        vec_t lu_v;
        idle();
        reset = 1'b0;
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        lu_v   = mk(0, 5, 0, 1, 1, 5, 0, 0, E_LD, 0);

        tbl[0]  = idle_v;
        tbl[1]  = lu_v;
        tbl[2]  = mk(0, 0, 0, 1, 1, 0, 0, 0, E_RUN, 0);
        tbl[3]  = mk(7, 0, 1, 0, 1, 7, 0, 0, E_LD, 0);
        tbl[4]  = mk(7, 0, 0, 0, 1, 7, 0, 0, E_RUN, 0);
        tbl[5]  = mk(7, 7, 1, 1, 0, 7, 0, 0, E_RUN, 0);
        tbl[6]  = mk(0, 5, 0, 1, 1, 5, 1, 0, E_BR, 0);
        tbl[7]  = mk(3, 4, 1, 1, 0, 9, 1, 0, E_BR, 0);
        tbl[8]  = mk(9, 2, 1, 1, 1, 9, 0, 0, E_LD, 0);
        tbl[9]  = mk(0, 31, 0, 1, 1, 31, 0, 0, E_LD, 0);
        tbl[10] = mk(31, 31, 1, 1, 1, 30, 0, 0, E_RUN, 0);

        #3;
        check("rst_ctrl", 32'(act_ctrl()), 32'(E_RUN));
        check("rst_frozen", 32'(frozen), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        check("rst_flush", 32'(flush_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i], $sformatf("vec%0d", i));
        end

        // Three-cycle memory access: two frozen cycles then release
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, E_FRZ, 1), "mem_c1");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, E_FRZ, 1), "mem_c2");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0), "mem_c3");
        drive(idle_v, "mem_idle");

        // Branch held through a freeze is flushed on release
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, E_FRZ, 1), "mbr_c1");
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, E_FRZ, 1), "mbr_c2");
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, E_BR, 0), "mbr_c3");

        // Load-use held through a freeze stalls on release
        drive(mk(0, 5, 0, 1, 1, 5, 0, 1, E_FRZ, 1), "mlu_c1");
        drive(mk(0, 5, 0, 1, 1, 5, 0, 1, E_FRZ, 1), "mlu_c2");
        drive(mk(0, 5, 0, 1, 1, 5, 0, 1, E_LD, 0), "mlu_c3");
        drive(idle_v, "mlu_idle");

        // Reset in the middle of a memory wait
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, E_FRZ, 1), "rw_c1");
        idle();
        #1;
        check("rw_wait_frozen", 32'(frozen), 32'd1);
        reset = 1'b0;
        #1;
        sb.delete();
        m_sc = 4'd0;
        m_fc = 4'd0;
        check("rw_ctrl", 32'(act_ctrl()), 32'(E_RUN));
        check("rw_frozen", 32'(frozen), 32'd0);
        check("rw_stall", 32'(stall_count), 32'd0);
        check("rw_flush", 32'(flush_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rw_post_ctrl", 32'(act_ctrl()), 32'(E_RUN));
        check("rw_post_frozen", 32'(frozen), 32'd0);
        check("rw_post_stall", 32'(stall_count), 32'd0);
        drive(idle_v, "rw_idle");

        // Saturation of the 4-bit stall counter
        for (int i = 0; i < 20; i++) begin
            drive(lu_v, $sformatf("sat%0d", i));
        end
        check("sat_final", 32'(stall_count), 32'd15);
        check("sat_flush", 32'(flush_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
